// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: op codes, the {N,Z,V,C} flag
// struct and the issue FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return !((op == 3'b001) || (op == 3'b111));
  endfunction

  // Only arithmetic ops produce meaningful V and C.
  function automatic logic op_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// 4-bit load/decrement counter that times the ALU settle window; done is
// high while the count is zero.
module alu_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one operation at a time to an external combinational ALU, waits
// SETTLE_CYCLES, captures result/flags and returns them. ALU_OP_CHECK_EN
// enables rejection of illegal op codes with rsp_err.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [2:0]  req_op,
  input  logic        req_setflags,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [2:0]  alu_cntrl,
  input  logic [63:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [3:0]  flags_q,
  output logic [1:0]  fsm_state
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t state;
  flags_t flags_r;
  flags_t alu_flags;
  logic   setflags_q;
  logic   accept;
  logic   op_reject;
  logic   timer_done;

  // Handshakes: a request transfers when req_valid && req_ready at a rising
  // edge, a response when rsp_valid && rsp_ready; both are decoded from state.
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_ready && req_valid;
  assign fsm_state = state;
  assign flags_q   = flags_r;
  assign alu_flags = '{n: alu_negative, z: alu_zero, v: alu_overflow, c: alu_carry_out};

`ifdef ALU_OP_CHECK_EN
  assign op_reject = !op_legal(req_op);
`else
  assign op_reject = 1'b0;
`endif

  alu_settle_timer u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (accept && !op_reject),
    .load_val (SETTLE_LOAD),
    .dec      (state == ST_SETTLE),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cntrl  <= 3'b000;
      setflags_q <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 4'b0000;
      rsp_err    <= 1'b0;
      flags_r    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (op_reject) begin
              // Rejected ops never touch the ALU drive or the flag register.
              rsp_result <= '0;
              rsp_flags  <= 4'b0000;
              rsp_err    <= 1'b1;
              state      <= ST_RESP;
            end else begin
              alu_a      <= req_a;
              alu_b      <= req_b;
              alu_cntrl  <= req_op;
              setflags_q <= req_setflags;
              state      <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (timer_done) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
            if (setflags_q) begin
              flags_r.n <= alu_flags.n;
              flags_r.z <= alu_flags.z;
              if (op_arith(alu_cntrl)) begin
                flags_r.v <= alu_flags.v;
                flags_r.c <= alu_flags.c;
              end
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
